// File: rtl/cache_types.sv
// Shared types for the direct-mapped L1 cache.
//   state_e  : controller states (COMPARE, WRITEBACK, FILL)
//   line_t   : one 256-bit cache line
//   be_mask(): expands a 4-bit store byte enable at a word offset into a
//              line-wide bit mask used for the read-modify-write of a line
package cache_types;

  localparam int S_OFFSET_DEF = 5;
  localparam int S_INDEX_DEF  = 3;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, FILL} state_e;

  typedef logic [255:0] line_t;

  function automatic line_t be_mask(input logic [3:0] be, input logic [2:0] word);
    line_t m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[32*int'(word) + 8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/cache_control.sv
// Cache controller FSM.
//   req_i/we_i        : CPU request pending / request is a store
//   hit_i             : tag match on a valid line at the request index
//   victim_dirty_i    : line at the request index is valid and dirty
//   pmem_resp_i       : burst complete
//   state_o           : current state (drives address/data muxing in the top)
//   mem_resp_o        : CPU request completes this cycle
//   pmem_read_o/_write_o : burst requests, held until pmem_resp_i
//   load_word_o       : store hit, merge store data into the line
//   load_line_o       : fill complete, install line/tag, valid=1, dirty=0
//   clr_dirty_o       : writeback complete, clear dirty
module cache_control
  import cache_types::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   we_i,
  input  logic   hit_i,
  input  logic   victim_dirty_i,
  input  logic   pmem_resp_i,
  output state_e state_o,
  output logic   mem_resp_o,
  output logic   pmem_read_o,
  output logic   pmem_write_o,
  output logic   load_word_o,
  output logic   load_line_o,
  output logic   clr_dirty_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= COMPARE;
    else      state_q <= state_d;
  end

  // Outputs depend only on state_q and CPU-side inputs, so an async reset
  // drops any outstanding pmem request immediately.
  always_comb begin
    state_d      = state_q;
    mem_resp_o   = 1'b0;
    pmem_read_o  = 1'b0;
    pmem_write_o = 1'b0;
    load_word_o  = 1'b0;
    load_line_o  = 1'b0;
    clr_dirty_o  = 1'b0;
    unique case (state_q)
      COMPARE: begin
        if (req_i) begin
          if (hit_i) begin
            mem_resp_o  = 1'b1;
            load_word_o = we_i;
          end else if (victim_dirty_i) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write_o = 1'b1;
        if (pmem_resp_i) begin
          clr_dirty_o = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        pmem_read_o = 1'b1;
        if (pmem_resp_i) begin
          load_line_o = 1'b1;
          state_d     = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache.
//   CPU side : mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable in,
//              mem_rdata/mem_resp out (hits answer in the same cycle)
//   Memory   : pmem_read/pmem_write/pmem_address/pmem_wdata out,
//              pmem_rdata/pmem_resp in (256-bit line bursts)
//   rst      : asynchronous, active low; clears valid/dirty, not data/tags
module dm_cache
  import cache_types::*;
#(
  parameter int S_OFFSET = S_OFFSET_DEF,
  parameter int S_INDEX  = S_INDEX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int S_TAG = 32 - S_OFFSET - S_INDEX;
  localparam int NSETS = 1 << S_INDEX;

  logic [S_TAG-1:0] tag_q [NSETS];
  line_t            data_q [NSETS];
  logic [NSETS-1:0] valid_q, dirty_q;

  logic [S_INDEX-1:0]  idx;
  logic [S_TAG-1:0]    tag;
  logic [2:0]          word;
  logic                hit, victim_dirty;
  logic                load_word, load_line, clr_dirty;
  state_e              state;
  logic                unused_addr_lsb;

  assign idx  = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign tag  = mem_address[31:S_OFFSET+S_INDEX];
  assign word = mem_address[S_OFFSET-1:2];
  assign unused_addr_lsb = ^mem_address[1:0];

  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  cache_control u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .req_i          (mem_read | mem_write),
    .we_i           (mem_write),
    .hit_i          (hit),
    .victim_dirty_i (victim_dirty),
    .pmem_resp_i    (pmem_resp),
    .state_o        (state),
    .mem_resp_o     (mem_resp),
    .pmem_read_o    (pmem_read),
    .pmem_write_o   (pmem_write),
    .load_word_o    (load_word),
    .load_line_o    (load_line),
    .clr_dirty_o    (clr_dirty)
  );

  // Output muxing; everything forced to zero while reset is asserted.
  always_comb begin
    mem_rdata    = '0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (rst) begin
      mem_rdata = data_q[idx][32*int'(word) +: 32];
      unique case (state)
        WRITEBACK: begin
          pmem_address = {tag_q[idx], idx, {S_OFFSET{1'b0}}};
          pmem_wdata   = data_q[idx];
        end
        FILL:    pmem_address = {tag, idx, {S_OFFSET{1'b0}}};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_line) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (clr_dirty) begin
      dirty_q[idx] <= 1'b0;
    end else if (load_word) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Data and tag storage is not reset; valid_q gates its use.
  always_ff @(posedge clk) begin
    if (load_line) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= tag;
    end else if (load_word) begin
      data_q[idx] <= (data_q[idx] & ~be_mask(mem_byte_enable, word)) |
                     ({8{mem_wdata}} & be_mask(mem_byte_enable, word));
    end
  end

endmodule
